// File: rtl/pixel_packer_pkg.sv
// Shared types and defaults for the pixel packer.
// Exports packer_state_t, axis_word_t and words_per_frame().
package pixel_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH
  } packer_state_t;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 380;
  localparam int DEF_PIX_W    = 16;
  localparam int AXIS_W       = 128;
  localparam int WIDX_W       = 14;

  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } axis_word_t;

  function automatic int words_per_frame(
    input int h,
    input int v,
    input int pw
  );
    return (h * v) / (AXIS_W / pw);
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI-Stream buffer (data + last), head always in e0.
// Ports: clk_in, rst_in (sync, low), push/push_word, ready, head, valid, occ.
module axis_fifo2
  import pixel_packer_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  axis_word_t push_word,
  input  logic       ready,
  output axis_word_t head,
  output logic       valid,
  output logic [1:0] occ
);

  axis_word_t e0;
  axis_word_t e1;
  logic       pop;
  logic       wr;

  assign valid = (occ != 2'd0);
  assign head  = e0;
  assign pop   = ready & valid;
  // A pop from full frees a slot in the same cycle.
  assign wr    = push & ((occ != 2'd2) | pop);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case ({wr, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= push_word;
          else e1 <= push_word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= push_word;
          end else begin
            e0 <= e1;
            e1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs raster pixels into 128-bit AXIS words, one TLAST per frame.
// Ports: clk_in, rst_in (sync, low), pixel_*/hcount/vcount in,
// write_axis_* out (ready in), frame/error counters, busy_out.
// Optional macro PIXEL_PACKER_TEST_PATTERN_EN adds test_pattern_in.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int PIX_W    = DEF_PIX_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-1:0]  pixel_data_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
  input  logic              test_pattern_in,
`endif
  output logic [AXIS_W-1:0] write_axis_data,
  output logic              write_axis_valid,
  output logic              write_axis_tlast,
  output logic              write_axis_smallpile,
  input  logic              write_axis_ready,
  output logic [15:0]       frame_count_out,
  output logic [7:0]        error_count_out,
  output logic              busy_out
);

  localparam int PIX_PER_WORD = AXIS_W / PIX_W;
  localparam int WORDS_PER_FRAME =
    words_per_frame(H_ACTIVE, V_ACTIVE, PIX_W);
  localparam logic [WIDX_W-1:0] LAST_IDX =
    WIDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [2:0] LAST_PIX = 3'(PIX_PER_WORD - 1);

  packer_state_t     state;
  logic [AXIS_W-1:0] word_q;
  logic [AXIS_W-1:0] word_next;
  logic [AXIS_W-1:0] stg_data;
  logic              stg_valid;
  logic [2:0]        pix_idx;
  logic [WIDX_W-1:0] word_idx;
  logic [PIX_W-1:0]  pix;
  logic              accept;
  logic              sof;
  logic              can_push;
  logic              stg_push;
  logic              flush_push;
  logic              push;
  logic              at_last;
  logic              last_push;
  logic              overflow;
  logic              early_sof;
  logic [1:0]        occ;
  axis_word_t        push_word;
  axis_word_t        head;

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
  logic [15:0] tp;
  assign tp  = {vcount_in[7:0], hcount_in[7:0]};
  assign pix = test_pattern_in ? PIX_W'(tp) : pixel_data_in;
`else
  assign pix = pixel_data_in;
`endif

  assign accept = pixel_valid_in
                & (hcount_in < 11'(H_ACTIVE))
                & (vcount_in < 10'(V_ACTIVE));
  assign sof = accept
             & (hcount_in == 11'd0)
             & (vcount_in == 10'd0);

  assign can_push   = (occ != 2'd2) | write_axis_ready;
  assign stg_push   = stg_valid & can_push;
  // Zero fill only once any staged real word has gone out.
  assign flush_push = (state == FLUSH) & ~stg_valid & can_push;
  assign push       = stg_push | flush_push;
  // word_idx counts pushed words, so a dropped word's slot is refilled.
  assign at_last    = (word_idx == LAST_IDX);
  assign last_push  = push & at_last;
  assign overflow   = (state == PACK) & stg_valid & ~can_push;
  // A SOF racing the frame's own last push is not an abort.
  assign early_sof  = (state == PACK) & sof
                    & ~(stg_valid & at_last) & ~overflow;

  assign push_word.last = at_last;
  assign push_word.data = stg_valid ? stg_data : '0;

  always_comb begin
    word_next = word_q;
    word_next[int'(pix_idx) * PIX_W +: PIX_W] = pix;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      word_q          <= '0;
      stg_data        <= '0;
      stg_valid       <= 1'b0;
      pix_idx         <= 3'd0;
      word_idx        <= '0;
      frame_count_out <= 16'd0;
      error_count_out <= 8'd0;
    end else begin
      if (push)
        word_idx <= at_last ? '0 : word_idx + WIDX_W'(1);
      if (push | overflow)
        stg_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sof) begin
            word_q  <= word_next;
            pix_idx <= 3'd1;
            state   <= PACK;
          end
        end
        PACK: begin
          if (overflow | early_sof) begin
            state   <= FLUSH;
            pix_idx <= 3'd0;
            if (error_count_out != 8'hff)
              error_count_out <= error_count_out + 8'd1;
          end else if (last_push) begin
            state           <= IDLE;
            pix_idx         <= 3'd0;
            frame_count_out <= frame_count_out + 16'd1;
          end else if (accept & ~sof) begin
            word_q  <= word_next;
            pix_idx <= pix_idx + 3'd1;
            if (pix_idx == LAST_PIX) begin
              stg_valid <= 1'b1;
              stg_data  <= word_next;
            end
          end
        end
        FLUSH: begin
          if (last_push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_fifo2 u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_word (push_word),
    .ready     (write_axis_ready),
    .head      (head),
    .valid     (write_axis_valid),
    .occ       (occ)
  );

  assign write_axis_data      = head.data;
  assign write_axis_tlast     = head.last & write_axis_valid;
  assign write_axis_smallpile = (occ != 2'd2);
  assign busy_out             = (state != IDLE);

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer on a reduced 32x8 raster.
// Expected words are queued as pixels are driven, popped on handshake.
module tb_pixel_packer;
  import pixel_packer_pkg::*;

  localparam int H   = 32;
  localparam int V   = 8;
  localparam int NPX = H * V;
  localparam int WPF = NPX / 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         pixel_valid_in;
  logic [15:0]  pixel_data_in;
  logic [10:0]  hcount_in;
  logic [9:0]   vcount_in;
  logic [127:0] write_axis_data;
  logic         write_axis_valid;
  logic         write_axis_tlast;
  logic         write_axis_smallpile;
  logic         write_axis_ready;
  logic [15:0]  frame_count_out;
  logic [7:0]   error_count_out;
  logic         busy_out;
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
  logic         test_pattern_in;
`endif

  int           checks   = 0;
  int           failures = 0;
  int           out_cnt  = 0;
  int           last_cnt = 0;
  logic [128:0] exp_q[$];
  bit           rand_mode   = 1'b0;
  logic         ready_force = 1'b1;
  bit           tp_mode     = 1'b0;

  always #5 clk_in = ~clk_in;

  pixel_packer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIX_W    (16)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pixel_valid_in       (pixel_valid_in),
    .pixel_data_in        (pixel_data_in),
    .hcount_in            (hcount_in),
    .vcount_in            (vcount_in),
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    .test_pattern_in      (test_pattern_in),
`endif
    .write_axis_data      (write_axis_data),
    .write_axis_valid     (write_axis_valid),
    .write_axis_tlast     (write_axis_tlast),
    .write_axis_smallpile (write_axis_smallpile),
    .write_axis_ready     (write_axis_ready),
    .frame_count_out      (frame_count_out),
    .error_count_out      (error_count_out),
    .busy_out             (busy_out)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    logic [128:0] e;
    if (rst_in && write_axis_valid && write_axis_ready) begin
      out_cnt++;
      if (write_axis_tlast) last_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed=%0h expected=none",
               write_axis_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", write_axis_data, e[127:0]);
        chk("sb_last", 128'(write_axis_tlast), 128'(e[128]));
      end
    end
  end

  initial begin
    write_axis_ready = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      write_axis_ready = rand_mode ?
        1'($urandom_range(0, 1)) : ready_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int n, input int n_exp, input int gap);
    logic [127:0] acc;
    logic [15:0]  pv;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      hcount_in      = 11'(i % H);
      vcount_in      = 10'(i / H);
      pixel_data_in  = 16'(i);
      pixel_valid_in = 1'b1;
      pv = tp_mode ? {8'(i / H), 8'(i % H)} : 16'(i);
      if (i < n_exp) begin
        acc[(i % 8) * 16 +: 16] = pv;
        if (i % 8 == 7)
          exp_q.push_back({(i / 8 == WPF - 1), acc});
      end
      step();
      pixel_valid_in = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic push_zeros(input int from);
    for (int w = from; w < WPF; w++)
      exp_q.push_back({(w == WPF - 1), 128'd0});
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 2000 && !(exp_q.size() == 0 && !busy_out
                         && !write_axis_valid)) begin
      @(negedge clk_in);
      k++;
    end
    checks++;
    assert (k < 2000) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=<2000", tag, k);
    end
    step();
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk_in);
    chki({tag, "_valid"}, 32'(write_axis_valid), 0);
    chki({tag, "_tlast"}, 32'(write_axis_tlast), 0);
    chk({tag, "_data"}, write_axis_data, '0);
    chki({tag, "_small"}, 32'(write_axis_smallpile), 1);
    chki({tag, "_frames"}, 32'(frame_count_out), 0);
    chki({tag, "_errors"}, 32'(error_count_out), 0);
    chki({tag, "_busy"}, 32'(busy_out), 0);
    step();
  endtask

  task automatic frame_stats(
    input string tag,
    input int    w0,
    input int    l0,
    input int    frames,
    input int    errs
  );
    chki({tag, "_words"}, 32'(out_cnt - w0), 32'(WPF));
    chki({tag, "_tlasts"}, 32'(last_cnt - l0), 1);
    chki({tag, "_frames"}, 32'(frame_count_out), 32'(frames));
    chki({tag, "_errors"}, 32'(error_count_out), 32'(errs));
  endtask

  initial begin
    int w0;
    int l0;
    rst_in         = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_data_in  = '0;
    hcount_in      = '0;
    vcount_in      = '0;
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    test_pattern_in = 1'b0;
`endif
    repeat (3) step();
    check_reset("reset");
    rst_in = 1'b1;
    step();

    w0 = out_cnt; l0 = last_cnt;
    send(NPX, NPX, 0);
    wait_idle("clean");
    frame_stats("clean", w0, l0, 1, 0);

    rand_mode = 1'b1;
    w0 = out_cnt; l0 = last_cnt;
    send(NPX, NPX, 3);
    wait_idle("random");
    rand_mode = 1'b0;
    frame_stats("random", w0, l0, 2, 0);
    step();

    ready_force = 1'b0;
    step();
    step();
    w0 = out_cnt; l0 = last_cnt;
    send(NPX, 16, 0);
    push_zeros(2);
    @(negedge clk_in);
    chki("ovf_errors", 32'(error_count_out), 1);
    chki("ovf_busy", 32'(busy_out), 1);
    chki("ovf_small", 32'(write_axis_smallpile), 0);
    chki("ovf_valid", 32'(write_axis_valid), 1);
    step();
    ready_force = 1'b1;
    wait_idle("ovf");
    frame_stats("ovf", w0, l0, 2, 1);
    chki("ovf_idle", 32'(busy_out), 0);

    w0 = out_cnt; l0 = last_cnt;
    send(64, 64, 0);
    send(1, 0, 0);
    push_zeros(8);
    wait_idle("esof");
    frame_stats("esof", w0, l0, 2, 2);

    w0 = out_cnt; l0 = last_cnt;
    send(NPX, NPX, 0);
    wait_idle("after_esof");
    frame_stats("after_esof", w0, l0, 3, 2);

    send(19, 16, 0);
    repeat (4) step();
    @(negedge clk_in);
    chki("mid_busy", 32'(busy_out), 1);
    step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check_reset("midrst");
    w0 = out_cnt; l0 = last_cnt;
    send(NPX, NPX, 0);
    wait_idle("after_rst");
    frame_stats("after_rst", w0, l0, 1, 0);

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
    tp_mode         = 1'b1;
    test_pattern_in = 1'b1;
    w0 = out_cnt; l0 = last_cnt;
    send(NPX, NPX, 0);
    wait_idle("tpat");
    frame_stats("tpat", w0, l0, 2, 0);
    tp_mode         = 1'b0;
    test_pattern_in = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
